// File: rtl/csr_file.sv
// Machine-mode CSR file with performance counters and an embedded polled 8N1 UART.
// Commit channels write in parallel. The highest channel wins on an address collision.

module uart_controller #(
  parameter int FREQ_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       txd,
  input  logic       send,
  input  logic [7:0] send_data,
  input  logic       rx_invalidate,
  output logic       tx_busy,
  output logic       rx_valid,
  output logic [7:0] rx_data
);
  localparam int CW = $clog2(FREQ_DIV);
  localparam logic [CW-1:0] LAST = CW'(FREQ_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(FREQ_DIV / 2 - 1);

  logic          rx_busy;
  logic [3:0]    rev_cnt;
  logic [CW-1:0] rev_clk_cnt;
  logic [7:0]    rx_shift;
  logic [3:0]    tx_cnt;
  logic [CW-1:0] tx_clk_cnt;
  logic [8:0]    tx_shift;

  // Receiver: rev_cnt 0 is the start bit, and 1..8 are the data bits sampled at mid-bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_busy     <= 1'b0;
      rev_cnt     <= '0;
      rev_clk_cnt <= '0;
      rx_shift    <= '0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
    end else begin
      if (rx_invalidate) rx_valid <= 1'b0;
      if (!rx_busy) begin
        if (!rxd) begin
          rx_busy     <= 1'b1;
          rev_cnt     <= '0;
          rev_clk_cnt <= '0;
        end
      end else begin
        if (rev_clk_cnt == LAST) begin
          rev_clk_cnt <= '0;
          rev_cnt     <= rev_cnt + 4'd1;
        end else begin
          rev_clk_cnt <= rev_clk_cnt + CW'(1);
        end
        if (rev_clk_cnt == HALF) begin
          if (rev_cnt != 4'd0 && rev_cnt <= 4'd8) rx_shift <= {rxd, rx_shift[7:1]};
          if (rev_cnt == 4'd8) begin
            rx_data  <= {rxd, rx_shift[7:1]};
            rx_valid <= 1'b1;
          end
          if (rev_cnt == 4'd9) rx_busy <= 1'b0;
        end
      end
    end
  end

  // Transmitter: the stop bit is the 1 that shifts into tx_shift[0] after 8 data bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_busy    <= 1'b0;
      txd        <= 1'b1;
      tx_cnt     <= '0;
      tx_clk_cnt <= '0;
      tx_shift   <= '1;
    end else if (send) begin
      tx_busy    <= 1'b1;
      txd        <= 1'b0;
      tx_shift   <= {1'b1, send_data};
      tx_cnt     <= '0;
      tx_clk_cnt <= '0;
    end else if (tx_busy) begin
      if (tx_clk_cnt == LAST) begin
        tx_clk_cnt <= '0;
        tx_cnt     <= tx_cnt + 4'd1;
        if (tx_cnt == 4'd9) begin
          tx_busy <= 1'b0;
          txd     <= 1'b1;
        end else begin
          txd      <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
        end
      end else begin
        tx_clk_cnt <= tx_clk_cnt + CW'(1);
      end
    end
  end
endmodule

module csr_file #(
  parameter int COMMIT_CSR_CHANNEL_NUM = 4,
  parameter int CSR_ADDR_WIDTH         = 12,
  parameter int REG_DATA_WIDTH         = 32,
  parameter int COMMIT_WIDTH           = 4,
  parameter int FREQ_DIV               = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CSR_ADDR_WIDTH-1:0]       excsr_csrf_addr,
  output logic [REG_DATA_WIDTH-1:0]       csrf_excsr_data,
  input  logic [CSR_ADDR_WIDTH-1:0]       commit_csrf_read_addr [COMMIT_CSR_CHANNEL_NUM],
  output logic [REG_DATA_WIDTH-1:0]       csrf_commit_read_data [COMMIT_CSR_CHANNEL_NUM],
  input  logic [CSR_ADDR_WIDTH-1:0]       commit_csrf_write_addr [COMMIT_CSR_CHANNEL_NUM],
  input  logic [REG_DATA_WIDTH-1:0]       commit_csrf_write_data [COMMIT_CSR_CHANNEL_NUM],
  input  logic [COMMIT_CSR_CHANNEL_NUM-1:0] commit_csrf_we,
  input  logic [REG_DATA_WIDTH-1:0]       intif_csrf_mip_data,
  output logic [REG_DATA_WIDTH-1:0]       csrf_all_mie_data,
  output logic [REG_DATA_WIDTH-1:0]       csrf_all_mstatus_data,
  output logic [REG_DATA_WIDTH-1:0]       csrf_all_mip_data,
  output logic [REG_DATA_WIDTH-1:0]       csrf_all_mepc_data,
  input  logic                            fetch_csrf_checkpoint_buffer_full_add,
  input  logic                            fetch_csrf_fetch_not_full_add,
  input  logic                            fetch_csrf_fetch_decode_fifo_full_add,
  input  logic                            decode_csrf_decode_rename_fifo_full_add,
  input  logic                            rename_csrf_phy_regfile_full_add,
  input  logic                            rename_csrf_rob_full_add,
  input  logic                            issue_csrf_issue_execute_fifo_full_add,
  input  logic                            issue_csrf_issue_queue_full_add,
  input  logic                            commit_csrf_branch_num_add,
  input  logic                            commit_csrf_branch_predicted_add,
  input  logic                            commit_csrf_branch_hit_add,
  input  logic                            commit_csrf_branch_miss_add,
  input  logic                            ras_csrf_ras_full_add,
  input  logic [$clog2(COMMIT_WIDTH):0]   commit_csrf_commit_num_add,
  input  logic                            rxd,
  output logic                            txd
);
  localparam int A = CSR_ADDR_WIDTH;
  localparam int D = REG_DATA_WIDTH;
  localparam int N = COMMIT_CSR_CHANNEL_NUM;
  localparam logic [A-1:0] A_MSTATUS = 'h300, A_MISA = 'h301, A_MIE = 'h304, A_MTVEC = 'h305;
  localparam logic [A-1:0] A_MSCRATCH = 'h340, A_MEPC = 'h341, A_MCAUSE = 'h342, A_MTVAL = 'h343;
  localparam logic [A-1:0] A_MIP = 'h344, A_MINSTRET = 'hB02, A_MARCHID = 'hF12, A_MIMPID = 'hF13;
  localparam logic [A-1:0] A_FINISH = 'h800, A_UART = 'h801, A_CB = 'h802, A_RAS = 'h80E;

  logic [D-1:0] mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip, minstret, finish;
  logic [D-1:0] cnt [13];
  logic [12:0]  cnt_add;
  logic         tx_busy, rx_valid, uart_we, uart_cmd, uart_send, uart_inv;
  logic [7:0]   rx_data, uart_byte;

  assign cnt_add = {ras_csrf_ras_full_add, commit_csrf_branch_miss_add, commit_csrf_branch_hit_add,
                    commit_csrf_branch_predicted_add, commit_csrf_branch_num_add,
                    issue_csrf_issue_queue_full_add, issue_csrf_issue_execute_fifo_full_add,
                    rename_csrf_rob_full_add, rename_csrf_phy_regfile_full_add,
                    decode_csrf_decode_rename_fifo_full_add, fetch_csrf_fetch_decode_fifo_full_add,
                    fetch_csrf_fetch_not_full_add, fetch_csrf_checkpoint_buffer_full_add};

  function automatic logic is_cnt(input logic [A-1:0] a);
    return (a >= A_CB) && (a <= A_RAS);
  endfunction

  function automatic logic [3:0] cnt_idx(input logic [A-1:0] a);
    return 4'(a - A_CB);
  endfunction

  function automatic logic [D-1:0] csr_read(input logic [A-1:0] a);
    logic [D-1:0] r;
    r = '0;
    case (a)
      A_MSTATUS:  r = mstatus;
      A_MISA:     r = D'(32'h4000_1100);
      A_MIE:      r = mie;
      A_MTVEC:    r = mtvec;
      A_MSCRATCH: r = mscratch;
      A_MEPC:     r = mepc;
      A_MCAUSE:   r = mcause;
      A_MTVAL:    r = mtval;
      A_MIP:      r = mip;
      A_MINSTRET: r = minstret;
      A_MARCHID:  r = D'(32'h1998_1001);
      A_MIMPID:   r = D'(32'h2022_0201);
      A_FINISH:   r = finish;
      A_UART: begin
        r[D-1]  = tx_busy;
        r[D-2]  = rx_valid;
        r[7:0]  = rx_data;
      end
      default:    if (is_cnt(a)) r = cnt[cnt_idx(a)];
    endcase
    return r;
  endfunction

  always_comb begin
    csrf_excsr_data = csr_read(excsr_csrf_addr);
    for (int i = 0; i < N; i++) csrf_commit_read_data[i] = csr_read(commit_csrf_read_addr[i]);
  end

  assign csrf_all_mie_data     = mie;
  assign csrf_all_mstatus_data = mstatus;
  assign csrf_all_mip_data     = mip;
  assign csrf_all_mepc_data    = mepc;

  always_comb begin
    uart_we   = 1'b0;
    uart_cmd  = 1'b0;
    uart_byte = '0;
    for (int i = 0; i < N; i++) begin
      if (commit_csrf_we[i] && commit_csrf_write_addr[i] == A_UART) begin
        uart_we   = 1'b1;
        uart_cmd  = commit_csrf_write_data[i][D-1];
        uart_byte = commit_csrf_write_data[i][7:0];
      end
    end
  end

  // A send while the transmitter is busy is silently dropped.
  assign uart_inv  = uart_we && uart_cmd;
  assign uart_send = uart_we && !uart_cmd && !tx_busy;

  // Increments come first so that a same-cycle write (later NBA) overrides them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus  <= '0;
      mie      <= '0;
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
      mip      <= '0;
      minstret <= '0;
      finish   <= '1;
      for (int k = 0; k < 13; k++) cnt[k] <= '0;
    end else begin
      mip      <= intif_csrf_mip_data;
      minstret <= minstret + D'(commit_csrf_commit_num_add);
      for (int k = 0; k < 13; k++) if (cnt_add[k]) cnt[k] <= cnt[k] + D'(1);
      for (int i = 0; i < N; i++) begin
        if (commit_csrf_we[i]) begin
          case (commit_csrf_write_addr[i])
            A_MSTATUS:  mstatus  <= commit_csrf_write_data[i];
            A_MIE:      mie      <= commit_csrf_write_data[i];
            A_MTVEC:    mtvec    <= commit_csrf_write_data[i];
            A_MSCRATCH: mscratch <= commit_csrf_write_data[i];
            A_MEPC:     mepc     <= commit_csrf_write_data[i];
            A_MCAUSE:   mcause   <= commit_csrf_write_data[i];
            A_MTVAL:    mtval    <= commit_csrf_write_data[i];
            A_MINSTRET: minstret <= commit_csrf_write_data[i];
            A_FINISH:   finish   <= commit_csrf_write_data[i];
            default: if (is_cnt(commit_csrf_write_addr[i]))
                       cnt[cnt_idx(commit_csrf_write_addr[i])] <= commit_csrf_write_data[i];
          endcase
        end
      end
    end
  end

  uart_controller #(.FREQ_DIV(FREQ_DIV)) u_uart (
    .clk          (clk),
    .rst          (rst),
    .rxd          (rxd),
    .txd          (txd),
    .send         (uart_send),
    .send_data    (uart_byte),
    .rx_invalidate(uart_inv),
    .tx_busy      (tx_busy),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data)
  );
endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: register map, commit write priority, counters, UART rx/tx.
// Inputs change on the falling edge and outputs are sampled just after it.

module tb_csr_file;
  localparam int N = 4;
  localparam int F = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] ex_addr;
  logic [31:0] ex_data;
  logic [11:0] rd_addr [N];
  logic [31:0] rd_data [N];
  logic [11:0] wr_addr [N];
  logic [31:0] wr_data [N];
  logic [N-1:0] we;
  logic [31:0] mip_in, all_mie, all_mstatus, all_mip, all_mepc;
  logic [12:0] add_v;
  logic [2:0]  commit_num;
  logic        rxd, txd;

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  csr_file dut (
    .clk(clk), .rst(rst),
    .excsr_csrf_addr(ex_addr), .csrf_excsr_data(ex_data),
    .commit_csrf_read_addr(rd_addr), .csrf_commit_read_data(rd_data),
    .commit_csrf_write_addr(wr_addr), .commit_csrf_write_data(wr_data), .commit_csrf_we(we),
    .intif_csrf_mip_data(mip_in),
    .csrf_all_mie_data(all_mie), .csrf_all_mstatus_data(all_mstatus),
    .csrf_all_mip_data(all_mip), .csrf_all_mepc_data(all_mepc),
    .fetch_csrf_checkpoint_buffer_full_add(add_v[0]),
    .fetch_csrf_fetch_not_full_add(add_v[1]),
    .fetch_csrf_fetch_decode_fifo_full_add(add_v[2]),
    .decode_csrf_decode_rename_fifo_full_add(add_v[3]),
    .rename_csrf_phy_regfile_full_add(add_v[4]),
    .rename_csrf_rob_full_add(add_v[5]),
    .issue_csrf_issue_execute_fifo_full_add(add_v[6]),
    .issue_csrf_issue_queue_full_add(add_v[7]),
    .commit_csrf_branch_num_add(add_v[8]),
    .commit_csrf_branch_predicted_add(add_v[9]),
    .commit_csrf_branch_hit_add(add_v[10]),
    .commit_csrf_branch_miss_add(add_v[11]),
    .ras_csrf_ras_full_add(add_v[12]),
    .commit_csrf_commit_num_add(commit_num),
    .rxd(rxd), .txd(txd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic check_pop(input string tag, input logic [31:0] got);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, got, e);
    end
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    ex_addr = a;
    #1;
    d = ex_data;
  endtask

  task automatic wr(input int ch, input logic [11:0] a, input logic [31:0] d);
    wr_addr[ch] = a;
    wr_data[ch] = d;
    we[ch] = 1'b1;
    @(negedge clk);
    we[ch] = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] b);
    logic [31:0] d;
    rxd = 1'b0;
    repeat (F) @(negedge clk);
    for (int k = 0; k < 7; k++) begin
      rxd = b[k];
      repeat (F) @(negedge clk);
    end
    rd(12'h801, d);
    check("rx_early_valid", {31'd0, d[30]}, 32'd0);
    rxd = b[7];
    repeat (F) @(negedge clk);
    rd(12'h801, d);
    check_pop("rx_byte", d);
    rxd = 1'b1;
    repeat (F) @(negedge clk);
    rd(12'h801, d);
    check("rx_hold", d, 32'h4000_0000 | {24'd0, b});
  endtask

  task automatic tx_frame(input logic [7:0] b, input logic try_drop);
    logic [31:0] d;
    logic [9:0]  bits;
    int cur;
    wr(1, 12'h801, {24'd0, b});
    cur = 1;
    rd(12'h801, d);
    check("tx_busy_set", {31'd0, d[31]}, 32'd1);
    exp_q.push_back({24'd0, b});
    if (try_drop) begin
      wr(2, 12'h801, {24'd0, ~b});
      cur++;
    end
    for (int k = 0; k < 10; k++) begin
      while (cur < k * F + F / 2) begin
        @(negedge clk);
        cur++;
      end
      bits[k] = txd;
    end
    check("tx_start_bit", {31'd0, bits[0]}, 32'd0);
    check("tx_stop_bit", {31'd0, bits[9]}, 32'd1);
    check_pop("tx_byte", {24'd0, bits[8:1]});
    while (cur < 10 * F) begin
      @(negedge clk);
      cur++;
    end
    rd(12'h801, d);
    check("tx_busy_end", {31'd0, d[31]}, 32'd1);
    @(negedge clk);
    rd(12'h801, d);
    check("tx_idle", {31'd0, d[31]}, 32'd0);
    check("tx_line_idle", {31'd0, txd}, 32'd1);
  endtask

  logic [31:0] d;
  logic [7:0]  byte_tab [12];

  initial begin
    rst = 1'b0;
    ex_addr = '0;
    we = '0;
    mip_in = '0;
    add_v = '0;
    commit_num = '0;
    rxd = 1'b1;
    for (int i = 0; i < N; i++) begin
      rd_addr[i] = '0;
      wr_addr[i] = '0;
      wr_data[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset state and constant IDs on every commit read port
    rd_addr[0] = 12'hF12; rd_addr[1] = 12'hF13; rd_addr[2] = 12'h301; rd_addr[3] = 12'h800;
    exp_q.push_back(32'h1998_1001); exp_q.push_back(32'h2022_0201);
    exp_q.push_back(32'h4000_1100); exp_q.push_back(32'hFFFF_FFFF);
    #1;
    for (int i = 0; i < N; i++) check_pop($sformatf("reset_id_ch%0d", i), rd_data[i]);
    check("reset_txd", {31'd0, txd}, 32'd1);
    rd(12'h801, d);
    check("reset_uart", d, 32'd0);
    rd(12'h80A, d);
    check("reset_counter", d, 32'd0);

    // All four channels write different CSRs in one cycle
    wr_addr[0] = 12'h340; wr_addr[1] = 12'h342; wr_addr[2] = 12'h343; wr_addr[3] = 12'h800;
    for (int i = 0; i < N; i++) begin
      wr_data[i] = 32'hFABC_1245 + i;
      rd_addr[i] = wr_addr[i];
      exp_q.push_back(32'hFABC_1245 + i);
    end
    we = '1;
    #1;
    check("no_bypass", rd_data[0], 32'd0);
    @(negedge clk);
    we = '0;
    #1;
    for (int i = 0; i < N; i++) check_pop($sformatf("multi_write_ch%0d", i), rd_data[i]);
    check("all_outputs_zero", all_mie | all_mstatus | all_mip | all_mepc, 32'd0);

    // mip follows its input and ignores commit writes
    mip_in = 32'h888;
    @(negedge clk);
    check("mip_load", all_mip, 32'h888);
    wr(0, 12'h344, 32'h123);
    check("mip_write_ignored", all_mip, 32'h888);

    wr(0, 12'h304, 32'h880);  check("mie_out", all_mie, 32'h880);
    wr(1, 12'h300, 32'h8);    check("mstatus_out", all_mstatus, 32'h8);
    wr(2, 12'h341, 32'hFF0);  check("mepc_out", all_mepc, 32'hFF0);

    // Same-address collision: highest channel wins; unmapped and constant writes ignored
    wr_addr[0] = 12'h340; wr_data[0] = 32'h11;
    wr_addr[1] = 12'h305; wr_data[1] = 32'h22;
    wr_addr[2] = 12'h7C0; wr_data[2] = 32'hDEAD;
    wr_addr[3] = 12'h340; wr_data[3] = 32'h33;
    we = '1;
    @(negedge clk);
    we = '0;
    rd(12'h340, d); check("priority_ch3", d, 32'h33);
    rd(12'h305, d); check("mtvec_parallel", d, 32'h22);
    rd(12'h7C0, d); check("unmapped_read", d, 32'd0);
    wr(0, 12'h301, 32'h0);
    rd(12'h301, d); check("misa_const", d, 32'h4000_1100);

    // Each counter: old value during the enable cycle, +1 after
    for (int i = 0; i < 13; i++) begin
      add_v = 13'd1 << i;
      rd(12'h802 + 12'(i), d);
      check($sformatf("cnt%0d_before", i), d, 32'd0);
      @(negedge clk);
      add_v = '0;
      rd(12'h802 + 12'(i), d);
      check($sformatf("cnt%0d_after", i), d, 32'd1);
    end
    add_v[0] = 1'b1;
    wr(3, 12'h802, 32'hFFFF_FFFF);
    rd(12'h802, d); check("cnt_write_overrides", d, 32'hFFFF_FFFF);
    @(negedge clk);
    add_v = '0;
    rd(12'h802, d); check("cnt_wrap", d, 32'd0);
    commit_num = 3'd4;
    @(negedge clk);
    commit_num = 3'd3;
    rd(12'hB02, d); check("minstret_4", d, 32'd4);
    @(negedge clk);
    commit_num = 3'd0;
    rd(12'hB02, d); check("minstret_7", d, 32'd7);

    // UART receive
    byte_tab[0] = 8'h00; byte_tab[1] = 8'hFF; byte_tab[2] = 8'hA5;
    byte_tab[3] = 8'h5A; byte_tab[4] = 8'h01; byte_tab[5] = 8'h80;
    for (int i = 6; i < 12; i++) byte_tab[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 12; i++) begin
      wr(0, 12'h801, 32'h8000_0000);
      rd(12'h801, d);
      check("rx_invalidated", {31'd0, d[30]}, 32'd0);
      exp_q.push_back(32'h4000_0000 | {24'd0, byte_tab[i]});
      rx_frame(byte_tab[i]);
    end
    wr(0, 12'h801, 32'h8000_0000);
    rd(12'h801, d);
    check("rx_final_invalidate", {31'd0, d[30]}, 32'd0);

    // UART transmit; the first frame also checks that a write while busy is dropped
    for (int i = 0; i < 12; i++) tx_frame(byte_tab[(i + 3) % 12], i == 0);

    // Reset mid-frame aborts the transmitter
    wr(0, 12'h801, 32'h0000_00C3);
    repeat (30) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_mid_txd", {31'd0, txd}, 32'd1);
    rd(12'h801, d); check("reset_mid_uart", d, 32'd0);
    rd(12'h800, d); check("reset_mid_finish", d, 32'hFFFF_FFFF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
